// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, S-box, SubWord/RotWord and Rcon helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NUM_ROUNDS_DEFAULT = 10;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t rcon(input logic [3:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_round
// Description : Combinational AES-128 key-schedule step (prev key, round -> next key).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  word_t w0, w1, w2, w3;
  word_t tem;
  word_t n0, n1, n2, n3;

  always_comb begin
    w0  = prev_key[127:96];
    w1  = prev_key[95:64];
    w2  = prev_key[63:32];
    w3  = prev_key[31:0];
    tem = sub_word(rot_word(w3)) ^ rcon(round);
    n0  = w0 ^ tem;
    n1  = n0 ^ w1;
    n2  = n1 ^ w2;
    n3  = n2 ^ w3;
    next_key = {n0, n1, n2, n3};
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key expansion into an 11-entry round-key file
//               with a registered read port. Optional macro
//               AES_KEY_EXPAND_ZEROIZE_EN clears the key file on reset/new key.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out,
  output logic         keys_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       key_ready_q, key_ready_d;
  logic       keys_ready_q, keys_ready_d;
  block_t     rk_q [NUM_ROUNDS+1];
  block_t     rk_d [NUM_ROUNDS+1];
  block_t     rk_out_q, rk_out_d;
  block_t     prev_key, next_key;
  logic       handshake;

  assign handshake = key_valid && key_ready_q;
  assign prev_key  = rk_q[round_q - 4'd1];

  aes_key_round u_round (
    .prev_key (prev_key),
    .round    (round_q),
    .next_key (next_key)
  );

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    keys_ready_d = keys_ready_q;
    rk_d         = rk_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (handshake) begin
          rk_d[0] = key_in;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            rk_d[i] = '0;
          end
`endif
          round_d      = 4'd1;
          keys_ready_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rk_d[round_q] = next_key;
        // Counter parks at the last round instead of wrapping.
        if (round_q == LAST_ROUND) begin
          keys_ready_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    key_ready_d = (state_d != ST_EXPAND);
    rk_out_d    = (int'(rk_addr) <= NUM_ROUNDS) ? rk_q[rk_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      key_ready_q  <= 1'b1;
      keys_ready_q <= 1'b0;
      rk_out_q     <= '0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      rk_q         <= '{default: '0};
`endif
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      key_ready_q  <= key_ready_d;
      keys_ready_q <= keys_ready_d;
      rk_out_q     <= rk_out_d;
      rk_q         <= rk_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign keys_ready = keys_ready_q;
  assign rk_out     = rk_out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand
// Description : Directed, table-driven bench for aes_key_expand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;
  logic         keys_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_addr    (rk_addr),
    .rk_out     (rk_out),
    .keys_ready (keys_ready)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
    rk_addr = a;
    tick();
    d = rk_out;
  endtask

  task automatic send_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check1("handshake key_ready", key_ready, 1'b0);
    check1("handshake keys_ready", keys_ready, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!keys_ready && n < 30);
  endtask

  initial begin
    logic [127:0] d;
    int           n;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h00000000000000000000000000000000,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5};

    reset     = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = 4'd0;
    tick();
    tick();
    check1("reset key_ready", key_ready, 1'b1);
    check1("reset keys_ready", keys_ready, 1'b0);
    check("reset rk_out", rk_out, 128'h0);
    reset = 1'b0;
    tick();

    // Each vector after the first is loaded from DONE.
    for (int i = 0; i < 3; i++) begin
      send_key(vecs[i].key);
      rk_addr = 4'd10;
      wait_ready(n);
      check_int("expansion latency", n, 10);
      if (i > 0) check("rk10 read during write is old", rk_out, vecs[i-1].rk10);
      check1("key_ready after done", key_ready, 1'b1);
      read_rk(4'd0, d);
      check("rk0", d, vecs[i].key);
      read_rk(4'd1, d);
      check("rk1", d, vecs[i].rk1);
      read_rk(4'd10, d);
      check("rk10", d, vecs[i].rk10);
    end

    // key_valid held through EXPAND with a different key is ignored.
    send_key(vecs[0].key);
    key_in    = vecs[1].key;
    key_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check1("key_ready low in expand", key_ready, 1'b0);
    end
    key_valid = 1'b0;
    tick();
    check1("keys_ready after held valid", keys_ready, 1'b1);
    read_rk(4'd10, d);
    check("held-valid rk10", d, vecs[0].rk10);
    read_rk(4'd0, d);
    check("held-valid rk0", d, vecs[0].key);

    for (int a = 11; a < 16; a++) begin
      read_rk(4'(a), d);
      check("out-of-range read", d, 128'h0);
    end

    // Reset while round 5 is pending.
    send_key(vecs[2].key);
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b1;
    tick();
    check1("mid reset keys_ready", keys_ready, 1'b0);
    check1("mid reset key_ready", key_ready, 1'b1);
    reset = 1'b0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    for (int a = 0; a <= 10; a++) begin
      read_rk(4'(a), d);
      check("zeroized entry", d, 128'h0);
    end
`else
    read_rk(4'd0, d);
    check("rk0 kept over reset", d, vecs[2].key);
`endif

    // Simultaneous reset and handshake: the key is dropped.
    send_key(vecs[1].key);
    wait_ready(n);
    check_int("reload latency", n, 10);
    reset     = 1'b1;
    key_valid = 1'b1;
    key_in    = vecs[0].key;
    tick();
    reset     = 1'b0;
    key_valid = 1'b0;
    check1("reset+hs key_ready", key_ready, 1'b1);
    check1("reset+hs keys_ready", keys_ready, 1'b0);
    for (int c = 0; c < 12; c++) tick();
    check1("dropped key no expansion", keys_ready, 1'b0);
    check1("dropped key still ready", key_ready, 1'b1);
    read_rk(4'd0, d);
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    check("dropped key rk0", d, 128'h0);
`else
    check("dropped key rk0", d, vecs[1].key);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule unit that sits directly upstream of the AES round datapath. It accepts a 128-bit cipher key over a valid/ready handshake and expands it into the 11 round keys, one round per clock. It holds them in an internal round-key file, and the cipher core reads them by round index through a registered read port. Expansion runs once per key, not once per block, so the cipher core never recomputes keys in its round loop.

## Interface
Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; the key file holds NUM_ROUNDS+1 entries, indices 0..NUM_ROUNDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_in  in  128  cipher key; word w0 = key_in[127:96] … w3 = key_in[31:0].
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  unit will accept a key this cycle.
- rk_addr  in  4  round-key index to read.
- rk_out  out  128  round key at rk_addr, registered.
- keys_ready  out  1  all NUM_ROUNDS+1 round keys are valid for the current key.

## Operation
- FSM states and transitions:
  - IDLE -> EXPAND on the key_valid && key_ready handshake.
  - EXPAND -> DONE after round NUM_ROUNDS is written.
  - DONE -> EXPAND on a new handshake.
- key_ready = 1 in IDLE and DONE; 0 in EXPAND. key_valid during EXPAND is ignored; the key is not queued.
- Handshake cycle:
  - rk[0] <= key_in.
  - round counter <= 1.
  - keys_ready <= 0.
- Each EXPAND cycle with counter r (1..NUM_ROUNDS):
  - Writes rk[r] = step(rk[r-1], r), then increments r.
  - step: tem = SubWord(RotWord(w3)) ^ Rcon(r).
  - w0' = w0^tem; w1' = w0'^w1; w2' = w1'^w2; w3' = w2'^w3.
- Rcon(r), MSB byte, for r = 1..10: 01,02,04,08,10,20,40,80,1b,36. The low three bytes are 0. Rcon for any other r is 0.
- Counter is 4 bits and never wraps: expansion stops at r = NUM_ROUNDS.
- Read port: rk_out <= rk[rk_addr] every cycle, independent of FSM state.
  - rk_addr > NUM_ROUNDS yields rk_out <= 0.
  - Reads during EXPAND return whatever is stored; only keys_ready qualifies content.
- Reset mid-expansion: FSM -> IDLE, counter -> 0, keys_ready -> 0. The partial key file is then handled per Configuration.

## Timing
- Reset values: key_ready = 1, keys_ready = 0, rk_out = 0, FSM = IDLE.
- Handshake at edge N:
  - rk[1] written at edge N+1.
  - rk[10] written at edge N+10.
  - keys_ready = 1 after edge N+10; key_ready = 1 after edge N+10.
- Expansion latency: NUM_ROUNDS cycles from handshake to keys_ready.
- New key accepted in DONE at edge M: keys_ready = 0 after edge M, re-asserts after edge M+10.
- Read latency: 1 cycle. Address presented before edge K gives data after edge K.
- A read of the index being written in the same cycle returns the old content.
- A simultaneous reset and handshake: reset wins and the key is dropped.

## Configuration
- AES_KEY_EXPAND_ZEROIZE_EN:
  - Defined: reset also clears all rk[] entries to 0, and a new handshake clears rk[1..NUM_ROUNDS] in the same cycle rk[0] loads. Stale key material is never readable.
  - Undefined: reset and handshake leave rk[] untouched except the entries written by the schedule. This saves reset fan-out; consumers must rely on keys_ready.

## Structure
- Shared package aes_pkg holds:
  - the sbox function and the SubWord/RotWord helpers;
  - the Rcon function;
  - the 32-bit word and 128-bit block typedefs;
  - the NUM_ROUNDS default constant.
  The cipher core reuses all of these.
- Sub-module aes_key_round: purely combinational one-round step (prev key, round index -> next key). It is instantiated once and shared across cycles.
- This block owns only the FSM, counter, key file and read register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - keys_ready rises exactly 10 cycles after the handshake.
- All-zero key:
  - rk[1] = 62636363626363636263636362636363.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high through EXPAND with a different key_in: key_ready = 0 throughout, and the result equals the first key's schedule.
- New key accepted in DONE: keys_ready drops the next cycle and the new rk[10] matches its reference after 10 cycles.
- Reset asserted at round 5:
  - keys_ready = 0 and key_ready = 1 the next cycle.
  - With ZEROIZE_EN, every rk_addr reads 0.
- rk_addr = 11..15 -> rk_out = 0. rk_addr = 0 -> the original key, one cycle later.
